// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : meter_pkg
// Brief    : Shared mode encodings, add amounts and presets for the meter path.
// Revision : 1.0
// ============================================================================
package meter_pkg;

  typedef enum logic [1:0] {
    MODE_EXPIRED = 2'd0,
    MODE_LOW     = 2'd1,
    MODE_NORMAL  = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  localparam int unsigned c_max_count_dflt = 9999;

  localparam logic [16:0] c_add_up    = 17'd10;
  localparam logic [16:0] c_add_left  = 17'd180;
  localparam logic [16:0] c_add_right = 17'd200;
  localparam logic [16:0] c_add_down  = 17'd550;

  localparam logic [15:0] c_preset_sw0 = 16'd10;
  localparam logic [15:0] c_preset_sw1 = 16'd205;

  // Edge vector is {down, right, left, up}; lower index wins.
  function automatic logic [16:0] add_amount(input logic [3:0] edges);
    logic [16:0] amt;
    amt = 17'd0;
    if (edges[0])      amt = c_add_up;
    else if (edges[1]) amt = c_add_left;
    else if (edges[2]) amt = c_add_right;
    else if (edges[3]) amt = c_add_down;
    return amt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meter_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Wrapping prescaler producing the 1 s tick and half-period strobes.
// Revision : 1.0
// ============================================================================
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic SYS_CLK,
  input  logic RESET_N,
  input  logic i_clear,
  output logic o_tick,
  output logic o_half
);

  localparam int unsigned     c_cw   = $clog2(TICK_DIV);
  localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);
  localparam logic [c_cw-1:0] c_mid  = c_cw'(TICK_DIV / 2 - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (i_clear || r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_last);
  assign o_half = (r_cnt == c_mid);

endmodule
`default_nettype wire

// File: rtl/meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : meter_ctrl
// Brief    : Parking-meter time counter: coin adds, presets, 1 s countdown, flash.
// Revision : 1.0
// ============================================================================
module meter_ctrl
  import meter_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned MAX_COUNT  = c_max_count_dflt,
  parameter int unsigned LOW_THRESH = 200
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        BTN_UP,
  input  logic        BTN_LEFT,
  input  logic        BTN_RIGHT,
  input  logic        BTN_DOWN,
  input  logic        SW0,
  input  logic        SW1,
  output logic [15:0] COUNT,
  output logic        BLANK,
  output logic [1:0]  MODE
);

  localparam logic [16:0] c_max17 = 17'(MAX_COUNT);
  localparam logic [15:0] c_low   = 16'(LOW_THRESH);

  logic [3:0]  r_btn_q;
  logic [15:0] r_count;
  mode_e       r_mode;
  logic        r_blank;

  logic [3:0]  w_btn;
  logic [3:0]  w_edge;
  logic        w_hold;
  logic        w_tick;
  logic        w_half;
  logic [16:0] w_sum;
  logic [16:0] w_sat;
  logic [15:0] w_count_nxt;
  mode_e       w_mode_nxt;
  logic        w_blank_nxt;

  assign w_btn  = {BTN_DOWN, BTN_RIGHT, BTN_LEFT, BTN_UP};
  assign w_edge = w_btn & ~r_btn_q;
  assign w_hold = SW0 | SW1;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .SYS_CLK (SYS_CLK),
    .RESET_N (RESET_N),
    .i_clear (w_hold),
    .o_tick  (w_tick),
    .o_half  (w_half)
  );

  always_comb begin
    w_sum       = {1'b0, r_count} + add_amount(w_edge);
    w_sat       = (w_sum > c_max17) ? c_max17 : w_sum;
    w_count_nxt = w_sat[15:0];
    w_mode_nxt  = MODE_NORMAL;
    w_blank_nxt = 1'b0;
    if (w_tick && w_sat != 17'd0) begin
      w_count_nxt = w_sat[15:0] - 16'd1;
    end
    if (w_hold) begin
      w_count_nxt = SW0 ? c_preset_sw0 : c_preset_sw1;
      w_mode_nxt  = MODE_HOLD;
    end else begin
      if (w_count_nxt == 16'd0)       w_mode_nxt = MODE_EXPIRED;
      else if (w_count_nxt < c_low)   w_mode_nxt = MODE_LOW;
      else                            w_mode_nxt = MODE_NORMAL;
      // A mode change leaves BLANK at 0 so the new mode opens on a visible phase.
      if (w_mode_nxt == r_mode) begin
        case (w_mode_nxt)
          MODE_LOW:     w_blank_nxt = r_blank ^ w_tick;
          MODE_EXPIRED: w_blank_nxt = r_blank ^ (w_tick | w_half);
          default:      w_blank_nxt = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_btn_q <= 4'd0;
      r_count <= 16'd0;
      r_mode  <= MODE_EXPIRED;
      r_blank <= 1'b0;
    end else begin
      r_btn_q <= w_btn;
      r_count <= w_count_nxt;
      r_mode  <= w_mode_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign COUNT = r_count;
  assign MODE  = r_mode;
  assign BLANK = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_meter_ctrl
// Brief    : Self-checking bench for meter_ctrl with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_meter_ctrl;

  localparam int TD = 10;

  logic        SYS_CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        BTN_UP = 1'b0, BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_DOWN = 1'b0;
  logic        SW0 = 1'b0, SW1 = 1'b0;
  logic [15:0] COUNT;
  logic        BLANK;
  logic [1:0]  MODE;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  meter_ctrl #(
    .TICK_DIV   (TD),
    .MAX_COUNT  (9999),
    .LOW_THRESH (200)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RESET_N   (RESET_N),
    .BTN_UP    (BTN_UP),
    .BTN_LEFT  (BTN_LEFT),
    .BTN_RIGHT (BTN_RIGHT),
    .BTN_DOWN  (BTN_DOWN),
    .SW0       (SW0),
    .SW1       (SW1),
    .COUNT     (COUNT),
    .BLANK     (BLANK),
    .MODE      (MODE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Reference model: plain integers, phase = seconds fraction elapsed.
  int       m_count = 0;
  int       m_mode  = 0;
  bit       m_blank = 1'b0;
  int       m_phase = 0;
  bit [3:0] m_prev  = 4'd0;
  int       amt_tab [4] = '{10, 180, 200, 550};
  bit [3:0] t_lv, t_ed;
  int       t_add, t_c, t_nm;
  bit       t_tk, t_hf;

  always @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_count = 0; m_mode = 0; m_blank = 1'b0; m_phase = 0; m_prev = 4'd0;
    end else begin
      t_lv   = {BTN_DOWN, BTN_RIGHT, BTN_LEFT, BTN_UP};
      t_ed   = t_lv & ~m_prev;
      m_prev = t_lv;
      t_tk   = (m_phase == TD - 1);
      t_hf   = (m_phase == TD / 2 - 1);
      if (SW0 || SW1) begin
        m_count = SW0 ? 10 : 205;
        m_mode  = 3;
        m_blank = 1'b0;
        m_phase = 0;
      end else begin
        t_add = 0;
        for (int i = 3; i >= 0; i--) if (t_ed[i]) t_add = amt_tab[i];
        t_c = m_count + t_add;
        if (t_c > 9999) t_c = 9999;
        if (t_tk && t_c > 0) t_c = t_c - 1;
        t_nm = (t_c == 0) ? 0 : (t_c < 200) ? 1 : 2;
        if (t_nm != m_mode)              m_blank = 1'b0;
        else if (t_nm == 1 && t_tk)      m_blank = ~m_blank;
        else if (t_nm == 0 && (t_tk || t_hf)) m_blank = ~m_blank;
        else if (t_nm == 2)              m_blank = 1'b0;
        m_count = t_c;
        m_mode  = t_nm;
        m_phase = (m_phase + 1) % TD;
      end
    end
  end

  always @(negedge SYS_CLK) begin
    if (mon_en) begin
      n_tests++;
      if (COUNT !== 16'(m_count) || MODE !== 2'(m_mode) || BLANK !== m_blank) begin
        n_fail++;
        $display("FAIL model t=%0t: got count=%0d mode=%0d blank=%0b, expected count=%0d mode=%0d blank=%0b",
                 $time, COUNT, MODE, BLANK, m_count, m_mode, m_blank);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic set_btn(input logic [3:0] m);
    {BTN_DOWN, BTN_RIGHT, BTN_LEFT, BTN_UP} = m;
  endtask

  typedef struct {
    bit          sw0;
    logic [3:0]  btn;
    logic [15:0] exp_count;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs [10];
  int   hold_left;
  int   hold_sel;
  bit   active;

  initial begin
    // btn mask is {down, right, left, up}
    vecs[0] = '{1'b0, 4'b0001, 16'd215, 2'd2};
    vecs[1] = '{1'b0, 4'b0101, 16'd215, 2'd2};
    vecs[2] = '{1'b0, 4'b1110, 16'd385, 2'd2};
    vecs[3] = '{1'b0, 4'b1100, 16'd405, 2'd2};
    vecs[4] = '{1'b0, 4'b1000, 16'd755, 2'd2};
    vecs[5] = '{1'b1, 4'b0000, 16'd10,  2'd1};
    vecs[6] = '{1'b1, 4'b0010, 16'd190, 2'd1};
    vecs[7] = '{1'b1, 4'b0100, 16'd210, 2'd2};
    vecs[8] = '{1'b1, 4'b1001, 16'd20,  2'd1};
    vecs[9] = '{1'b1, 4'b1000, 16'd560, 2'd2};

    cyc(2);
    chk("reset_count", 32'(COUNT), 0);
    chk("reset_mode",  32'(MODE), 0);
    chk("reset_blank", 32'(BLANK), 0);
    RESET_N = 1'b1;
    mon_en  = 1'b1;

    for (int k = 1; k <= 25; k++) begin
      cyc(1);
      chk("idle_blank", 32'(BLANK), 32'((k / 5) % 2));
    end
    chk("idle_count", 32'(COUNT), 0);

    BTN_DOWN = 1'b1;
    cyc(1);
    chk("down_count", 32'(COUNT), 550);
    chk("down_mode",  32'(MODE), 2);
    chk("down_blank", 32'(BLANK), 0);
    cyc(10);
    chk("down_tick", 32'(COUNT), 549);
    cyc(20);
    chk("down_held_once", 32'(COUNT), 547);
    BTN_DOWN = 1'b0;

    SW0 = 1'b1;
    cyc(2);
    chk("sw0_count", 32'(COUNT), 10);
    chk("sw0_mode",  32'(MODE), 3);
    SW0 = 1'b0;
    cyc(1);
    set_btn(4'b0101);
    cyc(1);
    chk("arb_up_right", 32'(COUNT), 20);
    set_btn(4'b0000);
    cyc(7);
    BTN_LEFT = 1'b1;
    cyc(1);
    chk("add_tick_count", 32'(COUNT), 199);
    chk("add_tick_mode",  32'(MODE), 1);
    chk("add_tick_blank", 32'(BLANK), 1);
    BTN_LEFT = 1'b0;

    for (int i = 0; i < 19; i++) begin
      BTN_DOWN = 1'b1; cyc(1);
      BTN_DOWN = 1'b0; cyc(1);
    end
    chk("sat_down", 32'(COUNT), 9999);
    BTN_UP = 1'b1;
    cyc(1);
    chk("sat_up", 32'(COUNT), 9999);
    BTN_UP = 1'b0;
    cyc(1);
    chk("sat_tick", 32'(COUNT), 9998);

    SW1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      BTN_LEFT = (i % 3 == 1);
      cyc(1);
      chk("hold_count", 32'(COUNT), 205);
      chk("hold_mode",  32'(MODE), 3);
    end
    SW1 = 1'b0;
    BTN_LEFT = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk("release_decr", 32'(COUNT), (k < 10) ? 205 : 204);
    end
    SW0 = 1'b1; SW1 = 1'b1;
    cyc(1);
    chk("both_sw", 32'(COUNT), 10);
    SW0 = 1'b0;
    cyc(2);
    SW1 = 1'b0;
    cyc(40);
    chk("run_201", 32'(COUNT), 201);
    cyc(20);
    chk("low_entry_count", 32'(COUNT), 199);
    chk("low_entry_mode",  32'(MODE), 1);
    chk("low_entry_blank", 32'(BLANK), 0);
    cyc(10);
    chk("low_toggle", 32'(BLANK), 1);
    cyc(1980);
    chk("exp_count", 32'(COUNT), 0);
    chk("exp_mode",  32'(MODE), 0);
    chk("exp_blank", 32'(BLANK), 0);
    cyc(5);
    chk("exp_half", 32'(BLANK), 1);
    cyc(5);
    chk("exp_tick", 32'(BLANK), 0);

    BTN_DOWN = 1'b1;
    cyc(1);
    chk("pre_reset", 32'(COUNT), 550);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_count", 32'(COUNT), 0);
    chk("async_mode",  32'(MODE), 0);
    chk("async_blank", 32'(BLANK), 0);
    @(negedge SYS_CLK);
    BTN_DOWN = 1'b0;
    RESET_N  = 1'b1;

    foreach (vecs[i]) begin
      SW0 = vecs[i].sw0; SW1 = ~vecs[i].sw0;
      cyc(2);
      SW0 = 1'b0; SW1 = 1'b0;
      cyc(1);
      set_btn(vecs[i].btn);
      cyc(1);
      chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_mode", i),  32'(MODE), 32'(vecs[i].exp_mode));
      set_btn(4'b0000);
      cyc(1);
    end

    hold_left = 0;
    hold_sel  = 1;
    active    = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) active = ($urandom_range(3) != 0);
      if (active) begin
        if ($urandom_range(3) == 0) BTN_UP    = ~BTN_UP;
        if ($urandom_range(3) == 0) BTN_LEFT  = ~BTN_LEFT;
        if ($urandom_range(3) == 0) BTN_RIGHT = ~BTN_RIGHT;
        if ($urandom_range(5) == 0) BTN_DOWN  = ~BTN_DOWN;
      end else begin
        set_btn(4'b0000);
      end
      if (hold_left > 0) begin
        hold_left--;
      end else if ($urandom_range(149) == 0) begin
        hold_left = $urandom_range(20, 1);
        hold_sel  = $urandom_range(3, 1);
      end
      SW0 = (hold_left > 0) && hold_sel[0];
      SW1 = (hold_left > 0) && hold_sel[1];
      if ($urandom_range(999) == 0) begin
        #2 RESET_N = 1'b0;
        @(negedge SYS_CLK);
        RESET_N = 1'b1;
      end else begin
        cyc(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
